// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared types and constants for the reaction-time game sequencer
package reaction_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      GO,
      RESULT,
      FALSE_START,
      TIMEOUT
   } state_t;

   localparam logic [1:0] MODE_NUM    = 2'd0;
   localparam logic [1:0] MODE_BLANK  = 2'd1;
   localparam logic [1:0] MODE_PROMPT = 2'd2;
   localparam logic [1:0] MODE_BLINK  = 2'd3;

   localparam logic [1:0] SEL_LIVE    = 2'd0;
   localparam logic [1:0] SEL_RESULT  = 2'd1;
   localparam logic [1:0] SEL_BEST    = 2'd2;
   localparam logic [1:0] SEL_ERR     = 2'd3;

   localparam logic [13:0] BEST_NONE  = 14'h3FFF;
   localparam logic [10:0] LFSR_SEED  = 11'h5A5;

   // x^11 + x^9 + 1, Fibonacci form shifting towards the MSB
   function automatic logic [10:0] lfsr_next(input logic [10:0] s);
      return {s[9:0], s[10] ^ s[8]};
   endfunction

endpackage

// File: rtl/reaction_lfsr.sv
// rtl/reaction_lfsr.sv - free-running 11-bit LFSR feeding the random pre-go delay
module reaction_lfsr
   import reaction_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] lfsr_o
);

   logic [10:0] lfsr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/reaction_controller.sv
// rtl/reaction_controller.sv - reaction-game sequencer: random delay, ms timer, best score, display bus
module reaction_controller
   import reaction_pkg::*;
#(
   parameter int          MS_DIV       = 100000,
   parameter int          MIN_DELAY_MS = 1000,
   parameter logic [10:0] DELAY_MASK   = 11'h7FF,
   parameter int          MAX_MS       = 9999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btnS,
   input  logic        btnU,
   input  logic        btnD,
   output logic [13:0] number,
   output logic [1:0]  mode,
   output logic [1:0]  select
);

   localparam int             PW         = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(MS_DIV - 1);
   localparam logic [13:0]    MAX_CNT    = 14'(MAX_MS);
   localparam logic [13:0]    MAX_LAST   = 14'(MAX_MS - 1);
   localparam logic [11:0]    MIN_DELAY  = 12'(MIN_DELAY_MS);

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [13:0]   ms_cnt_q, ms_cnt_d;
   logic [11:0]   delay_q, delay_d;
   logic [13:0]   result_q, result_d;
   logic [13:0]   best_q, best_d;
   logic          new_best_q, new_best_d;
   logic          show_best_q, show_best_d;
   logic [13:0]   number_q, number_d;
   logic [1:0]    mode_q, mode_d;
   logic [1:0]    select_q, select_d;

   logic [10:0]   lfsr;
   logic          tick;
   logic          entry;
   logic [13:0]   delay_last;
   logic [11:0]   new_delay;

   reaction_lfsr u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .lfsr_o (lfsr)
   );

   always_comb begin
      state_d     = state_q;
      ms_cnt_d    = ms_cnt_q;
      delay_d     = delay_q;
      result_d    = result_q;
      best_d      = best_q;
      new_best_d  = new_best_q;
      show_best_d = show_best_q;
      entry       = 1'b0;
      tick        = (presc_q == PRESC_LAST);
      presc_d     = tick ? '0 : presc_q + PW'(1);
      delay_last  = {2'b00, delay_q} - 14'd1;
      new_delay   = MIN_DELAY + {1'b0, lfsr & DELAY_MASK};

      case (state_q)
         ARM: begin
            // a press on the final tick still counts as jumping the gun
            if (btnS) begin
               state_d = FALSE_START;
               entry   = 1'b1;
            end else if (tick) begin
               if (ms_cnt_q == delay_last) begin
                  state_d = GO;
                  entry   = 1'b1;
               end else begin
                  ms_cnt_d = ms_cnt_q + 14'd1;
               end
            end
         end
         GO: begin
            if (btnS) begin
               state_d  = RESULT;
               entry    = 1'b1;
               result_d = ms_cnt_q;
               if (ms_cnt_q < best_q) begin
                  best_d     = ms_cnt_q;
                  new_best_d = 1'b1;
               end else begin
                  new_best_d = 1'b0;
               end
            end else if (tick) begin
               if (ms_cnt_q == MAX_LAST) begin
                  state_d  = TIMEOUT;
                  entry    = 1'b1;
                  result_d = MAX_CNT;
               end else begin
                  ms_cnt_d = ms_cnt_q + 14'd1;
               end
            end
         end
         default: begin
            if (btnS) begin
               state_d     = ARM;
               entry       = 1'b1;
               delay_d     = new_delay;
               show_best_d = 1'b0;
            end else if (btnD) begin
               best_d = BEST_NONE;
            end else if (btnU) begin
               show_best_d = ~show_best_q;
            end
         end
      endcase

      if (entry) begin
         presc_d  = '0;
         ms_cnt_d = '0;
      end
   end

   // display bus lags the game state by one cycle
   always_comb begin
      number_d = 14'd0;
      mode_d   = MODE_BLANK;
      select_d = SEL_LIVE;
      if (show_best_q) begin
         select_d = SEL_BEST;
         if (best_q != BEST_NONE) begin
            number_d = best_q;
            mode_d   = MODE_NUM;
         end
      end else begin
         case (state_q)
            ARM: mode_d = MODE_PROMPT;
            GO: begin
               number_d = ms_cnt_q;
               mode_d   = MODE_NUM;
            end
            RESULT: begin
               number_d = result_q;
               mode_d   = new_best_q ? MODE_BLINK : MODE_NUM;
               select_d = SEL_RESULT;
            end
            FALSE_START: begin
               mode_d   = MODE_BLINK;
               select_d = SEL_ERR;
            end
            TIMEOUT: begin
               number_d = MAX_CNT;
               mode_d   = MODE_BLINK;
               select_d = SEL_ERR;
            end
            default: mode_d = MODE_BLANK;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         presc_q     <= '0;
         ms_cnt_q    <= '0;
         delay_q     <= '0;
         result_q    <= '0;
         best_q      <= BEST_NONE;
         new_best_q  <= 1'b0;
         show_best_q <= 1'b0;
         number_q    <= '0;
         mode_q      <= MODE_BLANK;
         select_q    <= SEL_LIVE;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         ms_cnt_q    <= ms_cnt_d;
         delay_q     <= delay_d;
         result_q    <= result_d;
         best_q      <= best_d;
         new_best_q  <= new_best_d;
         show_best_q <= show_best_d;
         number_q    <= number_d;
         mode_q      <= mode_d;
         select_q    <= select_d;
      end
   end

   assign number = number_q;
   assign mode   = mode_q;
   assign select = select_q;

endmodule
